// File: rtl/cluster_acc_sequencer_pkg.sv
// Shared types and sizing helpers for the cluster accelerator sequencer.
// Rev 1.0
`default_nettype none

package cluster_acc_sequencer_pkg;

   localparam int unsigned MaxNrClusters = 16;

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      PRESENT = 1'b1
   } join_state_e;

   function automatic int unsigned cnt_width(input int unsigned max_outstanding);
      return $clog2(max_outstanding + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/cluster_acc_sequencer_resp_join.sv
// Joins one response per cluster into a single merged core response.
// Rev 1.0
`default_nettype none

module cluster_resp_join
   import cluster_acc_sequencer_pkg::*;
#(
   parameter int unsigned NrClusters  = 4,
   parameter int unsigned ResultWidth = 64
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              active_i,
   input  logic [NrClusters-1:0]             cl_resp_valid_i,
   output logic [NrClusters-1:0]             cl_resp_ready_o,
   input  logic [NrClusters*ResultWidth-1:0] cl_resp_result_i,
   input  logic [NrClusters-1:0]             cl_resp_error_i,
   output logic                              resp_valid_o,
   input  logic                              resp_ready_i,
   output logic [ResultWidth-1:0]            resp_result_o,
   output logic                              resp_error_o,
   output logic                              present_o,
   output logic                              resp_done_o
);

   join_state_e            state_q, state_d;
   logic [NrClusters-1:0]  got_q, got_d;
   logic [NrClusters-1:0]  err_q, err_d;
   logic [NrClusters-1:0]  hs;
   logic [ResultWidth-1:0] result_q, result_d;

   always_comb begin
      state_d         = state_q;
      got_d           = got_q;
      err_d           = err_q;
      result_d        = result_q;
      hs              = '0;
      cl_resp_ready_o = '0;
      resp_valid_o    = 1'b0;
      resp_done_o     = 1'b0;
      case (state_q)
         COLLECT: begin
            // Only accept responses when an instruction is actually in flight.
            cl_resp_ready_o = {NrClusters{active_i}} & ~got_q;
            hs              = cl_resp_valid_i & cl_resp_ready_o;
            got_d           = got_q | hs;
            err_d           = (err_q & ~hs) | (cl_resp_error_i & hs);
            if (hs[0]) begin
               result_d = cl_resp_result_i[ResultWidth-1:0];
            end
            if (&got_d) begin
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) begin
               state_d     = COLLECT;
               got_d       = '0;
               err_d       = '0;
               resp_done_o = 1'b1;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= COLLECT;
         got_q    <= '0;
         err_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         got_q    <= got_d;
         err_q    <= err_d;
         result_q <= result_d;
      end
   end

   assign resp_result_o = result_q;
   assign resp_error_o  = |err_q;
   assign present_o     = (state_q == PRESENT);

endmodule

`default_nettype wire

// File: rtl/cluster_acc_sequencer.sv
// Forks core accelerator requests to all clusters, joins their responses, bounds in-flight count.
// Rev 1.0
`default_nettype none

module cluster_acc_sequencer
   import cluster_acc_sequencer_pkg::*;
#(
   parameter  int unsigned NrClusters     = 4,
   parameter  int unsigned ResultWidth    = 64,
   parameter  int unsigned MaxOutstanding = 8,
   localparam int unsigned CntWidth       = cnt_width(MaxOutstanding)
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              req_valid_i,
   output logic                              req_ready_o,
   output logic [NrClusters-1:0]             cl_req_valid_o,
   input  logic [NrClusters-1:0]             cl_req_ready_i,
   input  logic [NrClusters-1:0]             cl_resp_valid_i,
   output logic [NrClusters-1:0]             cl_resp_ready_o,
   input  logic [NrClusters*ResultWidth-1:0] cl_resp_result_i,
   input  logic [NrClusters-1:0]             cl_resp_error_i,
   output logic                              resp_valid_o,
   input  logic                              resp_ready_i,
   output logic [ResultWidth-1:0]            resp_result_o,
   output logic                              resp_error_o,
   output logic [CntWidth-1:0]               outstanding_o,
   output logic                              busy_o
);

   if (NrClusters < 1 || NrClusters > MaxNrClusters) begin : g_bad_nr_clusters
      $error("NrClusters out of range");
   end

   logic [NrClusters-1:0] acc_mask_q, acc_mask_d;
   logic [NrClusters-1:0] done_vec;
   logic [CntWidth-1:0]   count_q, count_d;
   logic                  full;
   logic                  resp_done;
   logic                  present;

   assign full           = (count_q == CntWidth'(MaxOutstanding));
   assign cl_req_valid_o = {NrClusters{req_valid_i & ~full}} & ~acc_mask_q;
   assign done_vec       = acc_mask_q | (cl_req_ready_i & ~acc_mask_q);
   assign req_ready_o    = req_valid_i & ~full & (&done_vec);

   always_comb begin
      acc_mask_d = acc_mask_q | (cl_req_valid_o & cl_req_ready_i);
      if (req_ready_o) begin
         acc_mask_d = '0;
      end
      count_d = count_q;
      // Simultaneous fork and response leave the count untouched.
      case ({req_ready_o, resp_done})
         2'b10:   count_d = count_q + CntWidth'(1);
         2'b01:   count_d = count_q - CntWidth'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         acc_mask_q <= '0;
         count_q    <= '0;
      end else begin
         acc_mask_q <= acc_mask_d;
         count_q    <= count_d;
      end
   end

   cluster_resp_join #(
      .NrClusters  (NrClusters),
      .ResultWidth (ResultWidth)
   ) u_join (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .active_i         (count_q != '0),
      .cl_resp_valid_i  (cl_resp_valid_i),
      .cl_resp_ready_o  (cl_resp_ready_o),
      .cl_resp_result_i (cl_resp_result_i),
      .cl_resp_error_i  (cl_resp_error_i),
      .resp_valid_o     (resp_valid_o),
      .resp_ready_i     (resp_ready_i),
      .resp_result_o    (resp_result_o),
      .resp_error_o     (resp_error_o),
      .present_o        (present),
      .resp_done_o      (resp_done)
   );

   assign outstanding_o = count_q;
   assign busy_o        = (count_q != '0) | (acc_mask_q != '0) | present;

   // Withdrawing a request after some clusters already took it would desync them.
   a_no_partial_withdraw : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (acc_mask_q != '0) |-> req_valid_i);

endmodule

`default_nettype wire

// File: tb/tb_cluster_acc_sequencer.sv
// Scoreboard bench for cluster_acc_sequencer (4 clusters, 2 outstanding).
// Rev 1.0
`default_nettype none

module tb_cluster_acc_sequencer;

   localparam int NrClusters     = 4;
   localparam int ResultWidth    = 64;
   localparam int MaxOutstanding = 2;
   localparam int CntWidth       = $clog2(MaxOutstanding + 1);

   logic                              clk = 1'b0;
   logic                              rst_ni;
   logic                              req_valid;
   logic                              req_ready;
   logic [NrClusters-1:0]             cl_req_valid;
   logic [NrClusters-1:0]             cl_req_ready;
   logic [NrClusters-1:0]             cl_resp_valid;
   logic [NrClusters-1:0]             cl_resp_ready;
   logic [NrClusters*ResultWidth-1:0] cl_resp_result;
   logic [NrClusters-1:0]             cl_resp_error;
   logic                              resp_valid;
   logic                              resp_ready;
   logic [ResultWidth-1:0]            resp_result;
   logic                              resp_error;
   logic [CntWidth-1:0]               outstanding;
   logic                              busy;

   typedef struct packed {
      logic [ResultWidth-1:0] result;
      logic                   error;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   cluster_acc_sequencer #(
      .NrClusters     (NrClusters),
      .ResultWidth    (ResultWidth),
      .MaxOutstanding (MaxOutstanding)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_ni),
      .req_valid_i      (req_valid),
      .req_ready_o      (req_ready),
      .cl_req_valid_o   (cl_req_valid),
      .cl_req_ready_i   (cl_req_ready),
      .cl_resp_valid_i  (cl_resp_valid),
      .cl_resp_ready_o  (cl_resp_ready),
      .cl_resp_result_i (cl_resp_result),
      .cl_resp_error_i  (cl_resp_error),
      .resp_valid_o     (resp_valid),
      .resp_ready_i     (resp_ready),
      .resp_result_o    (resp_result),
      .resp_error_o     (resp_error),
      .outstanding_o    (outstanding),
      .busy_o           (busy)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Present a response from every cluster at once; optionally record the expected merge.
   task automatic drive_all_resp(input logic [NrClusters-1:0] err, input bit push);
      exp_t e;
      for (int c = 0; c < NrClusters; c++) begin
         cl_resp_result[c*ResultWidth +: ResultWidth] = {$urandom, $urandom};
      end
      cl_resp_valid = '1;
      cl_resp_error = err;
      e.result      = cl_resp_result[ResultWidth-1:0];
      e.error       = |err;
      if (push) sb_q.push_back(e);
   endtask

   task automatic drain_one();
      tick();
      drive_all_resp(4'($urandom_range(0, 15)), 1'b1);
      tick();
      cl_resp_valid = '0;
      cl_resp_error = '0;
      for (int i = 0; i < 8; i++) begin
         if (resp_valid) break;
         tick();
      end
      check_val("drain_resp_valid", resp_valid, 1);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_ni && resp_valid && resp_ready) begin
         if (sb_q.size() == 0) begin
            check_val("sb_unexpected", 64'(sb_q.size()), 64'd1);
         end else begin
            e = sb_q.pop_front();
            check_val("sb_result", resp_result, e.result);
            check_val("sb_error", resp_error, e.error);
         end
      end
   end

   initial begin
      rst_ni         = 1'b0;
      req_valid      = 1'b0;
      cl_req_ready   = '0;
      cl_resp_valid  = '0;
      cl_resp_result = '0;
      cl_resp_error  = '0;
      resp_ready     = 1'b0;
      repeat (3) tick();
      sample();
      check_val("rst_req_ready", req_ready, 0);
      check_val("rst_cl_req_valid", cl_req_valid, 0);
      check_val("rst_cl_resp_ready", cl_resp_ready, 0);
      check_val("rst_resp_valid", resp_valid, 0);
      check_val("rst_resp_result", resp_result, 0);
      check_val("rst_resp_error", resp_error, 0);
      check_val("rst_outstanding", outstanding, 0);
      check_val("rst_busy", busy, 0);
      tick();
      rst_ni = 1'b1;

      // All clusters ready: zero-cycle fork.
      tick();
      req_valid    = 1'b1;
      cl_req_ready = '1;
      sample();
      check_val("t1_cl_req_valid", cl_req_valid, 4'b1111);
      check_val("t1_req_ready", req_ready, 1);
      check_val("t1_outstanding_pre", outstanding, 0);
      tick();
      req_valid    = 1'b0;
      cl_req_ready = '0;
      sample();
      check_val("t1_outstanding_post", outstanding, 1);
      check_val("t1_cl_resp_ready", cl_resp_ready, 4'b1111);
      drain_one();

      // Staggered cluster acceptance.
      tick();
      req_valid    = 1'b1;
      cl_req_ready = 4'b0100;
      sample();
      check_val("t2_c0_valid", cl_req_valid, 4'b1111);
      check_val("t2_c0_ready", req_ready, 0);
      tick();
      cl_req_ready = 4'b0001;
      sample();
      check_val("t2_c1_valid", cl_req_valid, 4'b1011);
      check_val("t2_c1_ready", req_ready, 0);
      tick();
      cl_req_ready = 4'b0000;
      sample();
      check_val("t2_c2_valid", cl_req_valid, 4'b1010);
      check_val("t2_c2_ready", req_ready, 0);
      check_val("t2_c2_outstanding", outstanding, 0);
      tick();
      cl_req_ready = 4'b1010;
      sample();
      check_val("t2_c3_valid", cl_req_valid, 4'b1010);
      check_val("t2_c3_ready", req_ready, 1);
      tick();
      req_valid    = 1'b0;
      cl_req_ready = '0;
      sample();
      check_val("t2_outstanding", outstanding, 1);
      check_val("t2_busy", busy, 1);

      // Responses arrive from clusters 3, 1, 0, 2.
      sb_q.push_back('{result: 64'hDEAD_BEEF, error: 1'b1});
      tick();
      cl_resp_valid = 4'b1000;
      sample();
      check_val("t3_ready_a", cl_resp_ready, 4'b1111);
      tick();
      cl_resp_valid = 4'b0010;
      cl_resp_error = 4'b0010;
      sample();
      check_val("t3_ready_b", cl_resp_ready, 4'b0111);
      tick();
      cl_resp_valid  = 4'b0001;
      cl_resp_error  = 4'b0000;
      cl_resp_result[ResultWidth-1:0] = 64'hDEAD_BEEF;
      sample();
      check_val("t3_ready_c", cl_resp_ready, 4'b0101);
      tick();
      cl_resp_valid = 4'b0100;
      cl_resp_result[ResultWidth-1:0] = '0;
      sample();
      check_val("t3_ready_d", cl_resp_ready, 4'b0100);
      check_val("t3_valid_early", resp_valid, 0);
      tick();
      cl_resp_valid = '0;
      sample();
      check_val("t3_resp_valid", resp_valid, 1);
      check_val("t3_ready_present", cl_resp_ready, 0);
      check_val("t3_result", resp_result, 64'hDEAD_BEEF);
      check_val("t3_error", resp_error, 1);
      tick();
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      sample();
      check_val("t3_valid_after", resp_valid, 0);
      check_val("t3_outstanding", outstanding, 0);

      // Outstanding limit of 2.
      tick();
      req_valid    = 1'b1;
      cl_req_ready = '1;
      sample();
      check_val("t4_fork1", req_ready, 1);
      tick();
      sample();
      check_val("t4_fork2", req_ready, 1);
      check_val("t4_count1", outstanding, 1);
      tick();
      sample();
      check_val("t4_full_valid", cl_req_valid, 0);
      check_val("t4_full_ready", req_ready, 0);
      check_val("t4_count2", outstanding, 2);
      tick();
      drive_all_resp(4'b0000, 1'b1);
      sample();
      check_val("t4_still_full", req_ready, 0);
      tick();
      cl_resp_valid = '0;
      resp_ready    = 1'b1;
      sample();
      check_val("t4_present", resp_valid, 1);
      check_val("t4_blocked", req_ready, 0);
      tick();
      resp_ready = 1'b0;
      sample();
      check_val("t4_refork_ready", req_ready, 1);
      check_val("t4_refork_valid", cl_req_valid, 4'b1111);
      check_val("t4_count_dec", outstanding, 1);
      tick();
      req_valid    = 1'b0;
      cl_req_ready = '0;
      sample();
      check_val("t4_count_back", outstanding, 2);
      drain_one();
      drain_one();
      sample();
      check_val("t4_drained", outstanding, 0);

      // Fork and response handshake in the same cycle.
      tick();
      req_valid    = 1'b1;
      cl_req_ready = '1;
      tick();
      req_valid    = 1'b0;
      cl_req_ready = '0;
      drive_all_resp(4'b0100, 1'b1);
      tick();
      cl_resp_valid = '0;
      cl_resp_error = '0;
      req_valid     = 1'b1;
      cl_req_ready  = '1;
      resp_ready    = 1'b1;
      sample();
      check_val("t5_fork", req_ready, 1);
      check_val("t5_present", resp_valid, 1);
      tick();
      req_valid    = 1'b0;
      cl_req_ready = '0;
      resp_ready   = 1'b0;
      sample();
      check_val("t5_count", outstanding, 1);
      check_val("t5_valid_low", resp_valid, 0);
      check_val("t5_got_cleared", cl_resp_ready, 4'b1111);
      drain_one();

      // Reset mid-operation: partial fork plus PRESENT.
      tick();
      req_valid    = 1'b1;
      cl_req_ready = '1;
      tick();
      req_valid    = 1'b0;
      cl_req_ready = '0;
      drive_all_resp(4'b1111, 1'b0);
      tick();
      cl_resp_valid = '0;
      cl_resp_error = '0;
      req_valid     = 1'b1;
      cl_req_ready  = 4'b0101;
      sample();
      check_val("t6_present", resp_valid, 1);
      check_val("t6_partial_ready", req_ready, 0);
      tick();
      cl_req_ready = '0;
      sample();
      check_val("t6_mask", cl_req_valid, 4'b1010);
      check_val("t6_count", outstanding, 1);
      tick();
      rst_ni    = 1'b0;
      req_valid = 1'b0;
      tick();
      sample();
      check_val("t6_rst_cl_req_valid", cl_req_valid, 0);
      check_val("t6_rst_req_ready", req_ready, 0);
      check_val("t6_rst_resp_valid", resp_valid, 0);
      check_val("t6_rst_cl_resp_ready", cl_resp_ready, 0);
      check_val("t6_rst_result", resp_result, 0);
      check_val("t6_rst_error", resp_error, 0);
      check_val("t6_rst_outstanding", outstanding, 0);
      check_val("t6_rst_busy", busy, 0);
      tick();
      rst_ni       = 1'b1;
      req_valid    = 1'b1;
      cl_req_ready = '1;
      sample();
      check_val("t6_fresh_valid", cl_req_valid, 4'b1111);
      check_val("t6_fresh_ready", req_ready, 1);
      tick();
      req_valid    = 1'b0;
      cl_req_ready = '0;
      sample();
      check_val("t6_fresh_count", outstanding, 1);
      drain_one();

      sample();
      check_val("sb_drained", 64'(sb_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
